// File: rtl/stamp_timer_pkg.sv
// Shared types and default widths for the stamp_timer block.
// Slew FSM encoding lives here so the top and any debug tooling agree on it.
package stamp_timer_pkg;

    localparam int unsigned TS_WIDTH_DEFAULT  = 64;
    localparam int unsigned INC_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SLEW_UP   = 2'd1,
        ST_SLEW_DOWN = 2'd2
    } slew_state_e;

endpackage : stamp_timer_pkg

// File: rtl/stamp_timer_if.sv
// Control, slew and capture signals of stamp_timer bundled as one interface.
// The master side drives requests; the slave side is the timer itself.
interface stamp_timer_if
    import stamp_timer_pkg::*;
#(
    parameter int unsigned TIMESTAMP_WIDTH = TS_WIDTH_DEFAULT,
    parameter int unsigned INC_WIDTH       = INC_WIDTH_DEFAULT,
    parameter int unsigned NUM_CAPTURE     = 2
);

    logic                               en;
    logic [INC_WIDTH-1:0]               inc_value;
    logic                               load_valid;
    logic [TIMESTAMP_WIDTH-1:0]         load_value;
    logic                               adj_valid;
    logic                               adj_sign;
    logic [INC_WIDTH-1:0]               adj_value;
    logic                               adj_ready;
    logic [NUM_CAPTURE-1:0]             capture_req;
    logic [NUM_CAPTURE-1:0]             capture_ack;
    logic [NUM_CAPTURE-1:0]             capture_valid;
    logic [NUM_CAPTURE*TIMESTAMP_WIDTH-1:0] capture_stamp;
    logic [NUM_CAPTURE-1:0]             overrun;
    logic [NUM_CAPTURE-1:0]             overrun_clr;
    logic [TIMESTAMP_WIDTH-1:0]         stamp_counter;

    modport master (
        output en, inc_value, load_valid, load_value,
        output adj_valid, adj_sign, adj_value,
        output capture_req, capture_ack, overrun_clr,
        input  adj_ready, capture_valid, capture_stamp, overrun, stamp_counter
    );

    modport slave (
        input  en, inc_value, load_valid, load_value,
        input  adj_valid, adj_sign, adj_value,
        input  capture_req, capture_ack, overrun_clr,
        output adj_ready, capture_valid, capture_stamp, overrun, stamp_counter
    );

endinterface : stamp_timer_if

// File: rtl/stamp_capture.sv
// One snapshot channel: latches the running stamp on request, holds it until
// acknowledged, and flags a sticky overrun when a request finds it still full.
module stamp_capture
    import stamp_timer_pkg::*;
#(
    parameter int unsigned WIDTH = TS_WIDTH_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_i,
    input  logic             ack_i,
    input  logic             ovr_clr_i,
    input  logic [WIDTH-1:0] stamp_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] stamp_o,
    output logic             overrun_o
);

    logic             valid_q;
    logic [WIDTH-1:0] stamp_q;
    logic             overrun_q;
    logic             take;
    logic             lost;

    // An ack in the same cycle frees the slot, so the new sample is kept.
    assign take = req_i && (!valid_q || ack_i);
    assign lost = req_i && valid_q && !ack_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= 1'b0;
            stamp_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (take) begin
                stamp_q <= stamp_i;
                valid_q <= 1'b1;
            end else if (ack_i) begin
                valid_q <= 1'b0;
            end

            if (lost) begin
                overrun_q <= 1'b1;
            end else if (ovr_clr_i) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign valid_o   = valid_q;
    assign stamp_o   = stamp_q;
    assign overrun_o = overrun_q;

endmodule : stamp_capture

// File: rtl/stamp_timer.sv
// Free-running timestamp counter with load, bounded +/-1 slew correction and
// NUM_CAPTURE independent snapshot channels.
//
//   state        | meaning
//   ST_IDLE      | plain stepping by inc_value, slew requests accepted
//   ST_SLEW_UP   | stepping by inc_value+1 until rem is exhausted
//   ST_SLEW_DOWN | stepping by inc_value-1 (stalls while inc_value is 0)
module stamp_timer
    import stamp_timer_pkg::*;
#(
    parameter int unsigned TIMESTAMP_WIDTH = TS_WIDTH_DEFAULT,
    parameter int unsigned INC_WIDTH       = INC_WIDTH_DEFAULT,
    parameter int unsigned NUM_CAPTURE     = 2
) (
    input  logic         axi_aclk,
    input  logic         axi_reset,
    stamp_timer_if.slave bus
);

    slew_state_e                      state_q;
    logic [INC_WIDTH-1:0]             rem_q;
    logic                             adj_ready_q;
    logic [TIMESTAMP_WIDTH-1:0]       cnt_q;
    logic [TIMESTAMP_WIDTH-1:0]       cnt_d;
    logic [TIMESTAMP_WIDTH-1:0]       inc_ext;
    logic [TIMESTAMP_WIDTH-1:0]       step;
    logic                             slew_step;
    logic                             rem_dec;

    logic [NUM_CAPTURE-1:0]                 cap_valid;
    logic [NUM_CAPTURE-1:0]                 cap_ovr;
    logic [NUM_CAPTURE*TIMESTAMP_WIDTH-1:0] cap_stamp;

    always_comb begin
        inc_ext   = TIMESTAMP_WIDTH'(bus.inc_value);
        step      = inc_ext;
        slew_step = 1'b0;
        case (state_q)
            ST_SLEW_UP: begin
                step      = inc_ext + TIMESTAMP_WIDTH'(1);
                slew_step = 1'b1;
            end
            ST_SLEW_DOWN: begin
                // A zero increment cannot be slowed further; the slew waits.
                if (bus.inc_value != '0) begin
                    step      = inc_ext - TIMESTAMP_WIDTH'(1);
                    slew_step = 1'b1;
                end
            end
            default: ;
        endcase

        cnt_d = cnt_q;
        if (bus.load_valid) begin
            cnt_d = bus.load_value;
        end else if (bus.en) begin
            cnt_d = cnt_q + step;
        end

        rem_dec = slew_step && bus.en && !bus.load_valid;
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            adj_ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.adj_valid && (bus.adj_value != '0)) begin
                        rem_q       <= bus.adj_value;
                        state_q     <= bus.adj_sign ? ST_SLEW_DOWN : ST_SLEW_UP;
                        adj_ready_q <= 1'b0;
                    end
                end
                ST_SLEW_UP, ST_SLEW_DOWN: begin
                    if (rem_dec) begin
                        rem_q <= rem_q - INC_WIDTH'(1);
                        if (rem_q == INC_WIDTH'(1)) begin
                            state_q     <= ST_IDLE;
                            adj_ready_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rem_q       <= '0;
                    adj_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Channels snapshot the registered count, i.e. the value before this edge's update.
    for (genvar i = 0; i < NUM_CAPTURE; i++) begin : g_cap
        stamp_capture #(
            .WIDTH (TIMESTAMP_WIDTH)
        ) u_cap (
            .clk_i     (axi_aclk),
            .rst_i     (axi_reset),
            .req_i     (bus.capture_req[i]),
            .ack_i     (bus.capture_ack[i]),
            .ovr_clr_i (bus.overrun_clr[i]),
            .stamp_i   (cnt_q),
            .valid_o   (cap_valid[i]),
            .stamp_o   (cap_stamp[i*TIMESTAMP_WIDTH +: TIMESTAMP_WIDTH]),
            .overrun_o (cap_ovr[i])
        );
    end

    assign bus.stamp_counter = cnt_q;
    assign bus.adj_ready     = adj_ready_q;
    assign bus.capture_valid = cap_valid;
    assign bus.capture_stamp = cap_stamp;
    assign bus.overrun       = cap_ovr;

endmodule : stamp_timer

// File: tb/tb_stamp_timer.sv
// Directed scenarios followed by randomized traffic, every cycle compared
// against a behavioural model of the timestamp, slew budget and capture slots.
module tb_stamp_timer;

    localparam int unsigned TW = 64;
    localparam int unsigned IW = 32;
    localparam int unsigned NC = 2;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    stamp_timer_if #(.TIMESTAMP_WIDTH(TW), .INC_WIDTH(IW), .NUM_CAPTURE(NC)) bus ();

    stamp_timer #(
        .TIMESTAMP_WIDTH (TW),
        .INC_WIDTH       (IW),
        .NUM_CAPTURE     (NC)
    ) dut (
        .axi_aclk  (clk),
        .axi_reset (rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: the slew is an outstanding budget of +/-1 corrections.
    logic [TW-1:0] m_cnt;
    int unsigned   m_left;
    bit            m_down;
    bit            m_valid [NC];
    logic [TW-1:0] m_stamp [NC];
    bit            m_ovr   [NC];

    logic [TW-1:0] exp_slew [4];
    int            lows;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_next();
        logic [TW-1:0] inc64;
        logic [TW-1:0] step;
        bit            applied;
        if (rst) begin
            m_cnt  = '0;
            m_left = 0;
            m_down = 1'b0;
            for (int i = 0; i < NC; i++) begin
                m_valid[i] = 1'b0;
                m_stamp[i] = '0;
                m_ovr[i]   = 1'b0;
            end
            return;
        end
        inc64   = TW'(bus.inc_value);
        step    = inc64;
        applied = 1'b0;
        if (m_left != 0) begin
            if (!m_down) begin
                step    = inc64 + 1;
                applied = 1'b1;
            end else if (inc64 != 0) begin
                step    = inc64 - 1;
                applied = 1'b1;
            end
        end
        for (int i = 0; i < NC; i++) begin
            if (bus.overrun_clr[i]) m_ovr[i] = 1'b0;
            if (bus.capture_req[i]) begin
                if (!m_valid[i] || bus.capture_ack[i]) begin
                    m_stamp[i] = m_cnt;
                    m_valid[i] = 1'b1;
                end else begin
                    m_ovr[i] = 1'b1;
                end
            end else if (bus.capture_ack[i]) begin
                m_valid[i] = 1'b0;
            end
        end
        if (m_left == 0) begin
            if (bus.adj_valid && bus.adj_value != 0) begin
                m_left = bus.adj_value;
                m_down = bus.adj_sign;
            end
        end else if (applied && bus.en && !bus.load_valid) begin
            m_left--;
        end
        if (bus.load_valid) m_cnt = bus.load_value;
        else if (bus.en)    m_cnt = m_cnt + step;
    endtask

    task automatic compare_all();
        chk("stamp_counter", bus.stamp_counter, m_cnt);
        chk("adj_ready", 64'(bus.adj_ready), 64'(m_left == 0));
        for (int i = 0; i < NC; i++) begin
            chk($sformatf("capture_valid[%0d]", i), 64'(bus.capture_valid[i]), 64'(m_valid[i]));
            chk($sformatf("overrun[%0d]", i), 64'(bus.overrun[i]), 64'(m_ovr[i]));
            chk($sformatf("capture_stamp[%0d]", i), bus.capture_stamp[i*TW +: TW], m_stamp[i]);
        end
    endtask

    task automatic cyc();
        model_next();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        rst             = 1'b1;
        bus.en          = 1'b0;
        bus.inc_value   = '0;
        bus.load_valid  = 1'b0;
        bus.load_value  = '0;
        bus.adj_valid   = 1'b0;
        bus.adj_sign    = 1'b0;
        bus.adj_value   = '0;
        bus.capture_req = '0;
        bus.capture_ack = '0;
        bus.overrun_clr = '0;
        exp_slew = '{64'd25, 64'd36, 64'd47, 64'd57};

        cyc();
        cyc();
        chk("reset_stamp", bus.stamp_counter, 64'd0);
        chk("reset_adj_ready", 64'(bus.adj_ready), 64'd1);
        rst = 1'b0;

        // Count by one.
        bus.en        = 1'b1;
        bus.inc_value = 32'd1;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            chk("count_seq", bus.stamp_counter, 64'(i));
        end

        // Load near the top and wrap.
        bus.load_valid = 1'b1;
        bus.load_value = 64'hFFFF_FFFF_FFFF_FFFE;
        bus.inc_value  = 32'd3;
        cyc();
        chk("load_value", bus.stamp_counter, 64'hFFFF_FFFF_FFFF_FFFE);
        bus.load_valid = 1'b0;
        cyc();
        chk("wrap_1", bus.stamp_counter, 64'd1);
        cyc();
        chk("wrap_4", bus.stamp_counter, 64'd4);

        // Slew up by 3 at inc=10; a second request mid-slew must be ignored.
        bus.inc_value = 32'd10;
        bus.adj_valid = 1'b1;
        bus.adj_sign  = 1'b0;
        bus.adj_value = 32'd3;
        cyc();
        chk("slew_accept_step", bus.stamp_counter, 64'd14);
        lows = bus.adj_ready ? 0 : 1;
        for (int k = 0; k < 4; k++) begin
            bus.adj_valid = (k == 1);
            bus.adj_value = (k == 1) ? 32'd7 : 32'd3;
            cyc();
            chk("slew_up_step", bus.stamp_counter, exp_slew[k]);
            if (!bus.adj_ready) lows++;
        end
        bus.adj_valid = 1'b0;
        chk("adj_ready_low_cycles", 64'(lows), 64'd3);
        chk("adj_ready_after_slew", 64'(bus.adj_ready), 64'd1);

        // Slew down by 2 with inc=0 stalls, then completes once inc=5.
        bus.inc_value = 32'd0;
        bus.adj_valid = 1'b1;
        bus.adj_sign  = 1'b1;
        bus.adj_value = 32'd2;
        cyc();
        bus.adj_valid = 1'b0;
        chk("down_accept", bus.stamp_counter, 64'd57);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("down_hold", bus.stamp_counter, 64'd57);
            chk("down_hold_busy", 64'(bus.adj_ready), 64'd0);
        end
        bus.inc_value = 32'd5;
        cyc();
        chk("down_step_1", bus.stamp_counter, 64'd61);
        chk("down_busy", 64'(bus.adj_ready), 64'd0);
        cyc();
        chk("down_step_2", bus.stamp_counter, 64'd65);
        chk("down_done", 64'(bus.adj_ready), 64'd1);
        cyc();
        chk("down_idle_step", bus.stamp_counter, 64'd70);

        // Capture channel 0: fill, overrun, req+ack replace, clear, consume.
        bus.en         = 1'b0;
        bus.load_valid = 1'b1;
        bus.load_value = 64'd7;
        cyc();
        bus.load_valid  = 1'b0;
        bus.capture_req = 2'b01;
        cyc();
        bus.capture_req = 2'b00;
        chk("cap_valid", 64'(bus.capture_valid[0]), 64'd1);
        chk("cap_stamp_7", bus.capture_stamp[0 +: TW], 64'd7);
        bus.load_valid = 1'b1;
        bus.load_value = 64'd9;
        cyc();
        bus.load_valid  = 1'b0;
        bus.capture_req = 2'b01;
        cyc();
        bus.capture_req = 2'b00;
        chk("cap_overrun_keep", bus.capture_stamp[0 +: TW], 64'd7);
        chk("cap_overrun_flag", 64'(bus.overrun[0]), 64'd1);
        bus.load_valid = 1'b1;
        bus.load_value = 64'd12;
        cyc();
        bus.load_valid  = 1'b0;
        bus.capture_req = 2'b01;
        bus.capture_ack = 2'b01;
        cyc();
        bus.capture_req = 2'b00;
        bus.capture_ack = 2'b00;
        chk("cap_reqack_stamp", bus.capture_stamp[0 +: TW], 64'd12);
        chk("cap_reqack_valid", 64'(bus.capture_valid[0]), 64'd1);
        chk("cap_reqack_ovr", 64'(bus.overrun[0]), 64'd1);
        bus.overrun_clr = 2'b01;
        cyc();
        bus.overrun_clr = 2'b00;
        chk("cap_ovr_clr", 64'(bus.overrun[0]), 64'd0);
        bus.capture_ack = 2'b01;
        cyc();
        bus.capture_ack = 2'b00;
        chk("cap_ack_valid", 64'(bus.capture_valid[0]), 64'd0);
        chk("cap_ack_hold", bus.capture_stamp[0 +: TW], 64'd12);

        // Reset mid-slew with a held capture, competing with other requests.
        bus.en        = 1'b1;
        bus.inc_value = 32'd2;
        bus.adj_valid = 1'b1;
        bus.adj_sign  = 1'b0;
        bus.adj_value = 32'd20;
        cyc();
        bus.adj_valid   = 1'b0;
        bus.capture_req = 2'b10;
        cyc();
        bus.capture_req = 2'b00;
        cyc();
        chk("pre_reset_valid", 64'(bus.capture_valid[1]), 64'd1);
        chk("pre_reset_busy", 64'(bus.adj_ready), 64'd0);
        rst             = 1'b1;
        bus.load_valid  = 1'b1;
        bus.load_value  = 64'd5;
        bus.adj_valid   = 1'b1;
        bus.adj_value   = 32'd5;
        bus.capture_req = 2'b11;
        cyc();
        chk("rst_stamp", bus.stamp_counter, 64'd0);
        chk("rst_adj_ready", 64'(bus.adj_ready), 64'd1);
        chk("rst_valid", 64'(bus.capture_valid), 64'd0);
        chk("rst_overrun", 64'(bus.overrun), 64'd0);
        chk("rst_cap0", bus.capture_stamp[0 +: TW], 64'd0);
        chk("rst_cap1", bus.capture_stamp[TW +: TW], 64'd0);
        rst             = 1'b0;
        bus.load_valid  = 1'b0;
        bus.adj_valid   = 1'b0;
        bus.capture_req = 2'b00;
        cyc();
        chk("post_reset_step", bus.stamp_counter, 64'd2);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 149) == 0);
            bus.en = ($urandom_range(0, 7) != 0);
            case ($urandom_range(0, 3))
                0:       bus.inc_value = 32'd0;
                1:       bus.inc_value = 32'd1;
                2:       bus.inc_value = 32'($urandom_range(2, 1000));
                default: bus.inc_value = 32'hFFFF_FFFF;
            endcase
            bus.load_valid = ($urandom_range(0, 15) == 0);
            bus.load_value = ($urandom_range(0, 1) == 0) ? {$urandom, $urandom}
                           : (64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 8)));
            bus.adj_valid   = ($urandom_range(0, 5) == 0);
            bus.adj_sign    = 1'($urandom_range(0, 1));
            bus.adj_value   = 32'($urandom_range(0, 4));
            bus.capture_req = 2'($urandom_range(0, 3));
            bus.capture_ack = 2'($urandom_range(0, 3));
            bus.overrun_clr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_stamp_timer

// File: doc/stamp_timer.md
STAMP_TIMER -- requirements
Module: stamp_timer

Interface
REQ-001 SHALL have parameter TIMESTAMP_WIDTH, default 64: width of the timestamp counter and of all stamp values.
REQ-002 SHALL have parameter INC_WIDTH, default 32: width of the per-cycle increment and of the slew magnitude.
REQ-003 SHALL have parameter NUM_CAPTURE, default 2: number of independent snapshot channels (1..8).
REQ-004 SHALL have one clock and a synchronous, active-high reset, with ports named as follows.
REQ-005 axi_aclk  in  1  sole clock; all logic is on the rising edge.
REQ-006 axi_reset  in  1  synchronous, active-high reset.
REQ-007 en  in  1  counting enable; when low, the counter holds.
REQ-008 inc_value  in  INC_WIDTH  per-cycle increment, zero-extended into the counter width.
REQ-009 load_valid  in  1  single-cycle request to overwrite the counter.
REQ-010 load_value  in  TIMESTAMP_WIDTH  value to load.
REQ-011 adj_valid  in  1  slew request; accepted only while adj_ready is high.
REQ-012 adj_sign  in  1  slew direction: 0 speeds the counter up, 1 slows it down.
REQ-013 adj_value  in  INC_WIDTH  slew magnitude, in counts.
REQ-014 adj_ready  out  1  high only in state IDLE.
REQ-015 capture_req  in  NUM_CAPTURE  per-channel snapshot strobe.
REQ-016 capture_ack  in  NUM_CAPTURE  per-channel consume strobe.
REQ-017 capture_valid  out  NUM_CAPTURE  per-channel snapshot-held flag.
REQ-018 capture_stamp  out  NUM_CAPTURE*TIMESTAMP_WIDTH  held snapshots; channel i occupies bits [i*W +: W].
REQ-019 overrun  out  NUM_CAPTURE  per-channel sticky lost-capture flag.
REQ-020 overrun_clr  in  NUM_CAPTURE  per-channel clear for overrun.
REQ-021 stamp_counter  out  TIMESTAMP_WIDTH  registered running timestamp.

Function
REQ-022 Each cycle the counter SHALL update with this priority: load_valid, then en low (hold), then a step.
- load_valid high: the next value is load_value; the slew state is unaffected.
- en low: the counter holds.
- otherwise: the counter adds the step.
REQ-023 The counter SHALL use modulo-2^TIMESTAMP_WIDTH arithmetic: all-ones plus a step wraps with no flag and no stall.
REQ-024 The counter SHALL have 1-cycle latency: the effect of a request in cycle N is visible on stamp_counter in cycle N+1.
REQ-025 The FSM SHALL have states IDLE, SLEW_UP and SLEW_DOWN, plus a remaining-count register rem[INC_WIDTH-1:0].
REQ-026 In IDLE, adj_valid with adj_value != 0 SHALL load rem with adj_value and move to SLEW_UP (adj_sign=0) or SLEW_DOWN (adj_sign=1).
REQ-027 In IDLE, adj_value == 0 SHALL leave the FSM in IDLE; outside IDLE, adj_valid SHALL be ignored.
REQ-028 The step SHALL be selected by state:
- IDLE: inc_value.
- SLEW_UP: inc_value+1.
- SLEW_DOWN: inc_value-1, or 0 when inc_value == 0.
REQ-029 rem SHALL decrement by 1 only in cycles where a slew step (inc±1) is actually applied.
- No decrement when en is low or load_valid is high.
- No decrement in SLEW_DOWN when inc_value == 0.
REQ-030 The FSM SHALL return to IDLE in the cycle after the one in which rem goes from 1 to 0.
REQ-031 Capture SHALL behave as follows for channel i:
- capture_req[i] with capture_valid[i] low latches the current stamp_counter register value (pre-update) and sets capture_valid[i] in the next cycle.
REQ-032 capture_ack[i] SHALL clear capture_valid[i]; capture_stamp holds its value until it is overwritten.
REQ-033 capture_req[i] while capture_valid[i] is high and capture_ack[i] is low SHALL drop the new sample and set overrun[i].
REQ-034 capture_req[i] and capture_ack[i] in the same cycle while valid SHALL latch the new sample, keep valid high and leave overrun unchanged.
REQ-035 overrun[i] SHALL be cleared only by overrun_clr[i] or reset; a same-cycle set wins over clear.

Reset
REQ-036 axi_reset high SHALL set, in the next cycle:
- stamp_counter=0, state=IDLE, rem=0, adj_ready=1;
- capture_valid=0, capture_stamp=0, overrun=0.
REQ-037 Reset mid-slew SHALL abandon the remaining slew; reset SHALL dominate load_valid, adj_valid and capture_req.

Structure
REQ-038 Package stamp_timer_pkg SHALL hold the FSM state encoding and the default width constants (64, 32).
REQ-039 Per-channel capture logic SHALL be sub-module stamp_capture, instantiated NUM_CAPTURE times by a generate loop.

Verification
REQ-040 The bench SHALL cover these directed scenarios:
- Reset, en=1, inc=1, 5 cycles -> stamp_counter reads 1,2,3,4,5.
- load 0xFFFF_FFFF_FFFF_FFFE, inc=3 -> 0x...FFFE, then 0x1, then 0x4 (wrap).
- inc=10, adj_value=3, sign=0 -> steps 11,11,11,10; adj_ready is low for exactly 3 cycles after acceptance; a second adj_valid during the slew is ignored.
- inc=0, slew down by 2 -> counter holds and rem stays 2 (FSM never exits); then inc=5 -> steps 4,4 and the FSM returns to IDLE.
- Channel 0 req at counter=7, channel 0 req again at counter=9 with no ack -> stamp stays 7 and overrun[0]=1; req+ack at counter=12 -> stamp 12, valid stays 1; overrun_clr -> overrun 0.
- Reset asserted mid-slew with capture_valid set -> all outputs at reset values next cycle, adj_ready=1.
